// File: rtl/octree_op_sequencer_if.sv
// rtl/octree_op_sequencer_if.sv - command/engine handshake bundle for the octree op sequencer
// Purpose: groups the command queue, engine start/done and status signals.
// Signals (slave = sequencer side, master = command/engine side):
//   cmd_valid, cmd_op, cmd_ready : command queue handshake
//   abort                        : cancel current op and flush the queue
//   op_start, op_done            : one-hot engine start pulse / per-engine done pulses
//   mem_select, cur_op           : SRAM owner code / opcode being executed
//   busy, bad_cmd, timeout_err   : activity flag and one-cycle error pulses
//   done_cnt                     : saturating completed-operation count
interface octree_op_sequencer_if #(
    parameter int CONTROL_WIDTH = 8,
    parameter int NUM_OPS       = 3,
    parameter int SELECT_WIDTH  = 3,
    parameter int CNT_WIDTH     = 16
);
    logic                     cmd_valid;
    logic [CONTROL_WIDTH-1:0] cmd_op;
    logic                     cmd_ready;
    logic                     abort;
    logic [NUM_OPS-1:0]       op_start;
    logic [NUM_OPS-1:0]       op_done;
    logic [SELECT_WIDTH-1:0]  mem_select;
    logic [CONTROL_WIDTH-1:0] cur_op;
    logic                     busy;
    logic                     bad_cmd;
    logic                     timeout_err;
    logic [CNT_WIDTH-1:0]     done_cnt;

    modport slave (
        input  cmd_valid, cmd_op, abort, op_done,
        output cmd_ready, op_start, mem_select, cur_op, busy, bad_cmd, timeout_err, done_cnt
    );

    modport master (
        output cmd_valid, cmd_op, abort, op_done,
        input  cmd_ready, op_start, mem_select, cur_op, busy, bad_cmd, timeout_err, done_cnt
    );
endinterface

// File: rtl/octree_op_sequencer.sv
// rtl/octree_op_sequencer.sv - queued one-at-a-time dispatcher for octree operation engines
// Purpose: queues opcodes, hands each to its engine with a one-hot start pulse, owns the
//          SRAM mux select while the engine runs, and waits for done/abort/watchdog.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : octree_op_sequencer_if.slave (command queue, engine start/done, status)
module octree_op_sequencer #(
    parameter int                              CONTROL_WIDTH  = 8,
    parameter int                              NUM_OPS        = 3,
    parameter int                              SELECT_WIDTH   = 3,
    parameter logic [NUM_OPS*SELECT_WIDTH-1:0] OP_SEL_MAP     = {3'd2, 3'd2, 3'd1},
    parameter int                              FIFO_DEPTH     = 4,
    parameter int                              TIMEOUT_CYCLES = 1024,
    parameter int                              CNT_WIDTH      = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    octree_op_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [CONTROL_WIDTH-1:0] cur_op_q, cur_op_d;
    logic [SELECT_WIDTH-1:0]  mem_select_q, mem_select_d;
    logic [NUM_OPS-1:0]       op_start_q, op_start_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [CNT_WIDTH-1:0]     done_cnt_q, done_cnt_d;
    logic                     timeout_q, timeout_d;
    logic                     bad_cmd_q, bad_cmd_d;
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;
    logic [CONTROL_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     cmd_legal;
    logic                     push;
    logic                     pop;
    logic                     run_exit;
    logic                     done_hit;
    logic [CONTROL_WIDTH-1:0] head_op;
    logic [SELECT_WIDTH-1:0]  head_sel;
    logic [NUM_OPS-1:0]       start_vec;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cmd_legal  = (bus.cmd_op != '0) && (bus.cmd_op <= CONTROL_WIDTH'(NUM_OPS));
    // A same-cycle abort wins over an incoming command.
    assign push       = bus.cmd_valid && !fifo_full && cmd_legal && !bus.abort;
    assign bad_cmd_d  = bus.cmd_valid && !fifo_full && !cmd_legal;
    assign head_op    = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    // Abort flushes by snapping the read pointer onto the write pointer.
    assign wr_ptr_d = push ? (wr_ptr_q + (PTR_W+1)'(1)) : wr_ptr_q;
    assign rd_ptr_d = bus.abort ? wr_ptr_q : (pop ? (rd_ptr_q + (PTR_W+1)'(1)) : rd_ptr_q);

    // Opcode-to-engine decode; only the active engine's done bit is looked at.
    always_comb begin
        head_sel  = '0;
        start_vec = '0;
        done_hit  = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (head_op == CONTROL_WIDTH'(k + 1)) begin
                head_sel = OP_SEL_MAP[k*SELECT_WIDTH +: SELECT_WIDTH];
            end
            if (cur_op_q == CONTROL_WIDTH'(k + 1)) begin
                start_vec[k] = 1'b1;
                done_hit     = bus.op_done[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_op_d     = cur_op_q;
        mem_select_d = mem_select_q;
        op_start_d   = '0;
        timer_d      = timer_q;
        done_cnt_d   = done_cnt_q;
        timeout_d    = 1'b0;
        pop          = 1'b0;
        run_exit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Select is registered here so it is stable a cycle before op_start.
                if (!bus.abort && !fifo_empty) begin
                    pop          = 1'b1;
                    cur_op_d     = head_op;
                    mem_select_d = head_sel;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                if (bus.abort) begin
                    cur_op_d     = '0;
                    mem_select_d = '0;
                    state_d      = ST_IDLE;
                end else begin
                    op_start_d = start_vec;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                if (done_hit) begin
                    run_exit = 1'b1;
                    if (done_cnt_q != '1) begin
                        done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
                    end
                end else if (bus.abort) begin
                    run_exit = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    run_exit  = 1'b1;
                    timeout_d = 1'b1;
                end
                // Returning through IDLE with select 0 gives the SRAM a turnaround cycle.
                if (run_exit) begin
                    cur_op_d     = '0;
                    mem_select_d = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                cur_op_d     = '0;
                mem_select_d = '0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_op_q     <= '0;
            mem_select_q <= '0;
            op_start_q   <= '0;
            timer_q      <= '0;
            done_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            bad_cmd_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            cur_op_q     <= cur_op_d;
            mem_select_q <= mem_select_d;
            op_start_q   <= op_start_d;
            timer_q      <= timer_d;
            done_cnt_q   <= done_cnt_d;
            timeout_q    <= timeout_d;
            bad_cmd_q    <= bad_cmd_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.cmd_op;
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.op_start    = op_start_q;
    assign bus.mem_select  = mem_select_q;
    assign bus.cur_op      = cur_op_q;
    assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.bad_cmd     = bad_cmd_q;
    assign bus.timeout_err = timeout_q;
    assign bus.done_cnt    = done_cnt_q;
endmodule

// File: tb/tb_octree_op_sequencer.sv
// tb/tb_octree_op_sequencer.sv - directed self-checking bench for octree_op_sequencer
module tb_octree_op_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    octree_op_sequencer_if #(.CONTROL_WIDTH(8), .NUM_OPS(3), .SELECT_WIDTH(3), .CNT_WIDTH(16)) bus ();
    octree_op_sequencer_if #(.CONTROL_WIDTH(8), .NUM_OPS(3), .SELECT_WIDTH(3), .CNT_WIDTH(2)) bus2 ();

    octree_op_sequencer #(
        .CONTROL_WIDTH(8), .NUM_OPS(3), .SELECT_WIDTH(3), .OP_SEL_MAP({3'd2, 3'd2, 3'd1}),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024), .CNT_WIDTH(16)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    octree_op_sequencer #(
        .CONTROL_WIDTH(8), .NUM_OPS(3), .SELECT_WIDTH(3), .OP_SEL_MAP({3'd2, 3'd2, 3'd1}),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024), .CNT_WIDTH(2)
    ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;  bus.cmd_op = '0;  bus.abort = 1'b0;  bus.op_done = '0;
        bus2.cmd_valid = 1'b0; bus2.cmd_op = '0; bus2.abort = 1'b0; bus2.op_done = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b expected 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.op_start !== 3'b000) begin errors++; $display("FAIL reset_op_start: got %b expected 000", bus.op_start); end
        checks++; if (bus.mem_select !== 3'd0) begin errors++; $display("FAIL reset_mem_select: got %0d expected 0", bus.mem_select); end
        checks++; if (bus.cur_op !== 8'd0) begin errors++; $display("FAIL reset_cur_op: got %0d expected 0", bus.cur_op); end
        checks++; if (bus.done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d expected 0", bus.done_cnt); end
        checks++; if (bus.bad_cmd !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got bad_cmd=%0b timeout_err=%0b expected 0/0", bus.bad_cmd, bus.timeout_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_search();
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL search_busy_queued: got %0b expected 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.mem_select !== 3'd1) begin errors++; $display("FAIL search_mem_select: got %0d expected 1", bus.mem_select); end
        checks++; if (bus.cur_op !== 8'd1) begin errors++; $display("FAIL search_cur_op: got %0d expected 1", bus.cur_op); end
        checks++; if (bus.op_start !== 3'b000) begin errors++; $display("FAIL search_start_early: got %b expected 000", bus.op_start); end
        @(negedge clk);
        checks++; if (bus.op_start !== 3'b001) begin errors++; $display("FAIL search_op_start: got %b expected 001", bus.op_start); end
        bus.op_done = 3'b001;
        @(negedge clk);
        bus.op_done = 3'b000;
        checks++; if (bus.op_start !== 3'b000) begin errors++; $display("FAIL search_start_width: got %b expected 000", bus.op_start); end
        checks++; if (bus.done_cnt !== 16'd1) begin errors++; $display("FAIL search_done_cnt: got %0d expected 1", bus.done_cnt); end
        checks++; if (bus.mem_select !== 3'd0 || bus.cur_op !== 8'd0) begin errors++; $display("FAIL search_release: got sel=%0d op=%0d expected 0/0", bus.mem_select, bus.cur_op); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL search_busy_end: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_queue_fill();
        // Occupy the engine with a delete so nothing drains while adds arrive.
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.op_start !== 3'b100) begin errors++; $display("FAIL fill_delete_start: got %b expected 100", bus.op_start); end
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd2;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.cmd_ready !== (i < 4)) begin errors++; $display("FAIL fill_cmd_ready[%0d]: got %0b expected %0b", i, bus.cmd_ready, (i < 4)); end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.op_done = 3'b100;
        @(negedge clk);
        bus.op_done = 3'b000;
        checks++; if (bus.mem_select !== 3'd0) begin errors++; $display("FAIL fill_turnaround: got %0d expected 0", bus.mem_select); end
        checks++; if (bus.done_cnt !== 16'd2) begin errors++; $display("FAIL fill_delete_done: got %0d expected 2", bus.done_cnt); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_still_full: got %0b expected 0", bus.cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.mem_select !== 3'd2 || bus.cur_op !== 8'd2) begin errors++; $display("FAIL drain_select[%0d]: got sel=%0d op=%0d expected 2/2", i, bus.mem_select, bus.cur_op); end
            @(negedge clk);
            checks++; if (bus.op_start !== 3'b010) begin errors++; $display("FAIL drain_start[%0d]: got %b expected 010", i, bus.op_start); end
            bus.op_done = 3'b010;
            @(negedge clk);
            bus.op_done = 3'b000;
            checks++; if (bus.mem_select !== 3'd0) begin errors++; $display("FAIL drain_gap[%0d]: got %0d expected 0", i, bus.mem_select); end
        end
        checks++; if (bus.done_cnt !== 16'd6) begin errors++; $display("FAIL drain_done_cnt: got %0d expected 6", bus.done_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_illegal();
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd0;
        @(negedge clk);
        checks++; if (bus.bad_cmd !== 1'b1) begin errors++; $display("FAIL illegal_op0: got %0b expected 1", bus.bad_cmd); end
        bus.cmd_op = 8'd7;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.bad_cmd !== 1'b1) begin errors++; $display("FAIL illegal_op7: got %0b expected 1", bus.bad_cmd); end
        @(negedge clk);
        checks++; if (bus.bad_cmd !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end: got %0b expected 0", bus.bad_cmd); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_queue_empty: got busy=%0b expected 0", bus.busy); end
        @(negedge clk);
        checks++; if (bus.op_start !== 3'b000 || bus.mem_select !== 3'd0) begin errors++; $display("FAIL illegal_no_start: got start=%b sel=%0d expected 000/0", bus.op_start, bus.mem_select); end
    endtask

    task automatic test_timeout();
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.op_start !== 3'b100) begin errors++; $display("FAIL timeout_start: got %b expected 100", bus.op_start); end
        bus.op_done = 3'b001;
        @(negedge clk);
        bus.op_done = 3'b000;
        checks++; if (bus.cur_op !== 8'd3) begin errors++; $display("FAIL timeout_wrong_done: got cur_op=%0d expected 3", bus.cur_op); end
        repeat (1022) @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b0 || bus.mem_select !== 3'd2) begin errors++; $display("FAIL timeout_early: got err=%0b sel=%0d expected 0/2", bus.timeout_err, bus.mem_select); end
        @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_fire: got %0b expected 1", bus.timeout_err); end
        checks++; if (bus.mem_select !== 3'd0 || bus.cur_op !== 8'd0) begin errors++; $display("FAIL timeout_release: got sel=%0d op=%0d expected 0/0", bus.mem_select, bus.cur_op); end
        checks++; if (bus.done_cnt !== 16'd6) begin errors++; $display("FAIL timeout_done_cnt: got %0d expected 6", bus.done_cnt); end
        @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_single_pulse: got %0b expected 0", bus.timeout_err); end
    endtask

    task automatic test_abort();
        logic seen_start;
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd1;
        @(negedge clk);
        bus.cmd_op = 8'd2;
        @(negedge clk);
        bus.cmd_op = 8'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.op_start !== 3'b001) begin errors++; $display("FAIL abort_first_start: got %b expected 001", bus.op_start); end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++; if (bus.mem_select !== 3'd0 || bus.cur_op !== 8'd0) begin errors++; $display("FAIL abort_release: got sel=%0d op=%0d expected 0/0", bus.mem_select, bus.cur_op); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_flush: got busy=%0b expected 0", bus.busy); end
        checks++; if (bus.done_cnt !== 16'd6 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL abort_no_count: got cnt=%0d err=%0b expected 6/0", bus.done_cnt, bus.timeout_err); end
        seen_start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.op_start !== 3'b000) seen_start = 1'b1;
        end
        checks++; if (seen_start !== 1'b0) begin errors++; $display("FAIL abort_no_more_starts: got %0b expected 0", seen_start); end
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.op_start !== 3'b001) begin errors++; $display("FAIL abort_done_start: got %b expected 001", bus.op_start); end
        bus.op_done = 3'b001; bus.abort = 1'b1;
        @(negedge clk);
        bus.op_done = 3'b000; bus.abort = 1'b0;
        checks++; if (bus.done_cnt !== 16'd7) begin errors++; $display("FAIL abort_done_priority: got %0d expected 7", bus.done_cnt); end
        checks++; if (bus.mem_select !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_done_idle: got sel=%0d busy=%0b expected 0/0", bus.mem_select, bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        bus.cmd_valid = 1'b1; bus.cmd_op = 8'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.op_start !== 3'b010) begin errors++; $display("FAIL rstrun_start: got %b expected 010", bus.op_start); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_select !== 3'd0 || bus.cur_op !== 8'd0) begin errors++; $display("FAIL rstrun_async_release: got sel=%0d op=%0d expected 0/0", bus.mem_select, bus.cur_op); end
        checks++; if (bus.done_cnt !== 16'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstrun_async_state: got cnt=%0d busy=%0b expected 0/0", bus.done_cnt, bus.busy); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstrun_cmd_ready: got %0b expected 1", bus.cmd_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b0 || bus.bad_cmd !== 1'b0 || bus.op_start !== 3'b000) begin errors++; $display("FAIL rstrun_no_pulses: got err=%0b bad=%0b start=%b expected 0/0/000", bus.timeout_err, bus.bad_cmd, bus.op_start); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        for (int i = 0; i < 5; i++) begin
            bus2.cmd_valid = 1'b1; bus2.cmd_op = 8'd1;
            @(negedge clk);
            bus2.cmd_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++; if (bus2.op_start !== 3'b001) begin errors++; $display("FAIL sat_start[%0d]: got %b expected 001", i, bus2.op_start); end
            bus2.op_done = 3'b001;
            @(negedge clk);
            bus2.op_done = 3'b000;
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++; if (bus2.done_cnt !== exp_cnt) begin errors++; $display("FAIL sat_done_cnt[%0d]: got %0d expected %0d", i, bus2.done_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single_search();
        test_queue_fill();
        test_illegal();
        test_timeout();
        test_abort();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/octree_op_sequencer.md
Name: octree_op_sequencer

Overview:
- Parametrised successor to the octree top-level controller.
- Accepts operation commands (search, add anchor, delete anchor, plus further engine types) through a valid/ready queue.
- Dispatches one command at a time to NUM_OPS engines with a one-hot start pulse, and drives the SRAM mux select for the active engine.
- Waits for that engine's done, with abort, watchdog timeout, illegal-opcode rejection and a completion counter.

Parameters:
- CONTROL_WIDTH, 8: opcode width. Opcode 0 = no-op; 1..NUM_OPS = engine index+1.
- NUM_OPS, 3: number of engines (1 = search, 2 = add, 3 = delete by default).
- SELECT_WIDTH, 3: mem_select width.
- OP_SEL_MAP, {3'd2,3'd2,3'd1}: packed NUM_OPS*SELECT_WIDTH. Slice k holds the mem_select code for opcode k+1.
- FIFO_DEPTH, 4: command queue depth, power of two, ≥2.
- TIMEOUT_CYCLES, 1024: maximum RUN cycles before the watchdog fires. Must be ≥2.
- CNT_WIDTH, 16: width of done_cnt.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset. Asynchronous, active-low.
- cmd_valid, in, 1: command present.
- cmd_op, in, CONTROL_WIDTH: command opcode.
- cmd_ready, out, 1: queue can accept.
- abort, in, 1: cancel the current operation and flush the queue.
- op_start, out, NUM_OPS: one-hot single-cycle start pulse.
- op_done, in, NUM_OPS: per-engine done pulses.
- mem_select, out, SELECT_WIDTH: SRAM owner code. 0 = none.
- cur_op, out, CONTROL_WIDTH: opcode being executed. 0 when idle.
- busy, out, 1: FSM not IDLE, or queue non-empty.
- bad_cmd, out, 1: one-cycle pulse when an illegal opcode is dropped.
- timeout_err, out, 1: one-cycle pulse when the watchdog fires.
- done_cnt, out, CNT_WIDTH: completed-operation count, saturating.

Behaviour:
- Reset (async, rst_n low): FSM to IDLE, queue emptied, timer cleared. All outputs 0 except cmd_ready = 1.
- Reset mid-operation: abandons the operation immediately with no done or error pulse.
- Enqueue: occurs on edge with cmd_valid && cmd_ready.
  - cmd_ready = !full. No bypass when full.
  - Push and pop in the same cycle are both honoured.
  - Opcode 0 or >NUM_OPS is not stored; bad_cmd pulses the next cycle.
- FSM states: IDLE, START, RUN.
  - IDLE: if the queue is non-empty, pop the head. On that edge latch cur_op, set mem_select = OP_SEL_MAP[cur_op-1], go to START.
  - START: lasts exactly 1 cycle. op_start[cur_op-1] = 1 (registered, so the select is stable one cycle before the start). Timer cleared. Go to RUN.
  - RUN: timer increments each cycle. Exit priority: op_done[cur_op-1] > abort > timeout.
    - done: done_cnt += 1 (saturates at all-ones).
    - abort: flush the queue.
    - timeout: timer reaches TIMEOUT_CYCLES-1 → timeout_err pulse.
    - All three exits: mem_select ← 0, cur_op ← 0, go to IDLE.
- op_done bits of non-active engines are ignored in every state. op_done in START is ignored.
- Every operation ends with at least one IDLE cycle with mem_select = 0 (bus turnaround). Back-to-back commands therefore have an op_start spacing of done latency + 3 cycles.
- abort in IDLE or START:
  - Flushes the queue.
  - In START: suppresses op_start and returns to IDLE, clearing mem_select and cur_op.
  - An enqueue in the same cycle as abort is discarded.
- Latency: command accepted at edge E gives mem_select/cur_op valid after E+1, and op_start high during cycle E+2..E+3 (queue empty and FSM idle beforehand).
- busy falls in the first cycle where the FSM is IDLE and the queue is empty.

Test Plan:
- Reset then single search: cmd_op=1 → mem_select=1, cur_op=1 after E+1; op_start=3'b001 for one cycle at E+2; op_done=3'b001 → done_cnt=1, mem_select=0, busy=0.
- Queue fill: 5 back-to-back adds while the engine is stalled → 4 accepted (FIFO_DEPTH=4), cmd_ready low at 5th; op_done=3'b010 drains them in order, mem_select=2 each time with one 0 cycle between; done_cnt=4.
- Illegal/no-op: cmd_op=0, then cmd_op=7 → bad_cmd pulses twice, queue stays empty, op_start never asserted.
- Timeout: cmd_op=3, no done for 1024 RUN cycles → timeout_err single pulse, mem_select=0, done_cnt unchanged; a wrong-engine op_done=3'b001 during RUN is ignored.
- Abort: 3 commands queued, abort mid-RUN of first → IDLE next cycle, queue empty, busy=0, no op_start for the other two; simultaneous op_done and abort → counted as done.
- Reset mid-RUN and done_cnt saturation: rst_n low during RUN → all outputs 0 immediately (async); preload path via 2^CNT_WIDTH completions with CNT_WIDTH=2 → done_cnt holds 3.
